pipe_flush_ctrl: RTL and testbench
==================================

# pipe_flush_ctrl

Pipeline control generator that drives the `en` / `ResetPC` / `DPC` control inputs of the F/D/E/M stage registers. It combines three sources into per-register enable, clear and bubble-PC signals: data-hazard stalls, the multiply/divide busy window, and exception/eret redirects. It sits beside the hazard unit and CP0, and is the producer end of the stage-register control interface.

## Interface
Parameters:
- `HANDLER_PC`, 32'h0000_4180, exception entry address
- `PC_RESET`, 32'h0000_3000, bubble PC driven while in reset
- `MAX_STALL`, 64, watchdog threshold in cycles (only with the watchdog macro)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `hz_stall`  in  1  data-hazard stall request from D
- `md_use`  in  1  instruction in D needs the mult/div unit or HI/LO
- `md_start`  in  1  mult/div instruction issuing in E
- `md_cycles`  in  4  busy length of that op (5 or 10; 0 is legal)
- `exc_req`  in  1  exception or interrupt taken at M
- `eret_req`  in  1  eret at M
- `epc`  in  32  return address for eret
- `d_pc`  in  32  PC of the instruction in D
- `en_pc`, `en_ifid`, `en_idex`, `en_exmem`  out  1 each  register write enables
- `rst_ifid`, `rst_idex`, `rst_exmem`  out  1 each  register clear, driven to the `ResetPC` input
- `dpc`  out  32  PC loaded into a cleared register, driven to the `DPC` input
- `pc_redirect`  out  1  PC mux select to `pc_target`
- `pc_target`  out  32  redirect address
- `md_busy`  out  1  mult/div unit occupied
- `stall_timeout`  out  1  sticky watchdog flag

## Operation
- FSM states are RUN and MD_BUSY, with a 4-bit counter `cnt`.
- **RUN**
  - `md_start=1`, `exc_req=0`, `eret_req=0`, `md_cycles!=0`: load `cnt=md_cycles` and go to MD_BUSY.
  - `md_cycles=0`: stay in RUN.
- **MD_BUSY**
  - `cnt` decrements each cycle.
  - When `cnt==1`, go to RUN at the next edge.
  - `md_start` is ignored.
  - Exceptions do not abort the busy window; the HI/LO write completes.
- `md_busy = (state==MD_BUSY) | (state==RUN & md_start & ~exc_req & ~eret_req & md_cycles!=0)`.
- **Priority (combinational):** `exc_req` > `eret_req` > stall > normal.
  - **exc_req**
    - `rst_ifid`, `rst_idex` and `rst_exmem` = 1.
    - All enables = 1.
    - `pc_redirect=1`, `pc_target=HANDLER_PC`, `dpc=HANDLER_PC`.
    - A simultaneous `md_start` is dropped.
  - **eret_req:** same as exc_req, but `pc_target=dpc=epc`.
  - **stall** (`hz_stall | (md_busy & md_use)`)
    - `en_pc=en_ifid=0`.
    - `rst_idex=1`, `dpc=d_pc`, so the bubble carries D's PC.
    - `en_idex=en_exmem=1`; other clears 0.
  - **Normal**
    - All enables 1, all clears 0.
    - `pc_redirect=0`, `pc_target=dpc=d_pc`.
- **While `reset=0`** (dominates all inputs)
  - State is RUN and `cnt=0`.
  - All enables 0; `rst_ifid`, `rst_idex`, `rst_exmem` = 1.
  - `pc_redirect=0`, `pc_target=dpc=PC_RESET`.
  - `md_busy=0`, `stall_timeout=0`.
- **Reset mid-busy:** return to RUN immediately (asynchronous); the counter is cleared.

## Timing
- Enables, clears, `dpc`, `pc_redirect` and `pc_target` are combinational from the inputs and state, with zero latency.
- `md_start` in cycle t with `md_cycles=N`:
  - `md_busy` is high in cycles t..t+N (N+1 cycles).
  - The FSM is in MD_BUSY during cycles t+1..t+N.
  - RUN resumes at t+N+1.
- A `md_use` instruction in D stalls through cycle t+N and advances at t+N+1.
- An exception during MD_BUSY does not change `cnt`. `md_busy` stays high, so an instruction that uses md at the handler stalls until the window ends.
- `stall_timeout` is registered and rises one edge after the threshold is reached.

## Configuration
- **`PIPE_FLUSH_CTRL_WDOG_EN` defined**
  - An 8-bit saturating counter increments on each stall cycle and clears on any non-stall cycle.
  - When the count reaches `MAX_STALL`, `stall_timeout` is set and stays set until reset.
- **Not defined**
  - The counter is absent and `stall_timeout` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset low with `d_pc=32'hfac1_3215` -> all enables 0, three clears 1, `dpc=32'h3000`. Release reset -> enables 1, clears 0, `dpc=32'hfac1_3215`.
- `hz_stall=1` for 1 cycle with `d_pc=32'h3010` -> `en_pc=en_ifid=0`, `rst_idex=1`, `dpc=32'h3010`. The next cycle returns to normal.
- `md_start` with `md_cycles=5` at t, `md_use=1` held -> `md_busy` high t..t+5, stall t..t+5, `en_ifid=1` at t+6.
- `exc_req` with `hz_stall=1` and `md_start=1` (`md_cycles=10`) in the same cycle -> all clears 1, `pc_target=dpc=32'h4180`, `md_busy=0`, state stays RUN.
- `eret_req` with `epc=32'h3024` at cycle 3 of a 10-cycle busy window -> `pc_target=32'h3024`, `md_busy` stays high until the window ends. Reset pulled low mid-window -> `md_busy=0` immediately.
- With the macro defined and `MAX_STALL=4`: `hz_stall` held for 6 cycles -> `stall_timeout` rises and stays high after `hz_stall` drops. Without the macro -> `stall_timeout` stays 0.

Source files
------------

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: stage-register enable/clear/bubble-PC generator for stalls, mult/div busy and exception/eret redirects.
// Optional stall watchdog enabled by defining PIPE_FLUSH_CTRL_WDOG_EN.
module pipe_flush_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PC_RESET   = 32'h0000_3000
`ifdef PIPE_FLUSH_CTRL_WDOG_EN
    , parameter int MAX_STALL = 64
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        md_use,
    input  logic        md_start,
    input  logic [3:0]  md_cycles,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic [31:0] d_pc,
    output logic        en_pc,
    output logic        en_ifid,
    output logic        en_idex,
    output logic        en_exmem,
    output logic        rst_ifid,
    output logic        rst_idex,
    output logic        rst_exmem,
    output logic [31:0] dpc,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        md_busy,
    output logic        stall_timeout
);
    typedef enum logic {RUN, MD_BUSY} state_t;
    state_t state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic md_go, stall;

    // A redirect in the same cycle drops the issuing mult/div op.
    assign md_go   = (state == RUN) & md_start & ~exc_req & ~eret_req & (md_cycles != 4'd0);
    assign md_busy = reset & ((state == MD_BUSY) | md_go);
    assign stall   = hz_stall | (md_busy & md_use);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (md_go) begin
            state_nx = MD_BUSY;
            cnt_nx   = md_cycles;
        end else if (state == MD_BUSY) begin
            cnt_nx   = cnt - 4'd1;
            state_nx = (cnt == 4'd1) ? RUN : MD_BUSY;
        end
    end

    always_comb begin
        en_pc       = 1'b1;
        en_ifid     = 1'b1;
        en_idex     = 1'b1;
        en_exmem    = 1'b1;
        rst_ifid    = 1'b0;
        rst_idex    = 1'b0;
        rst_exmem   = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = d_pc;
        dpc         = d_pc;
        if (!reset) begin
            {en_pc, en_ifid, en_idex, en_exmem} = 4'b0000;
            {rst_ifid, rst_idex, rst_exmem}     = 3'b111;
            pc_target = PC_RESET;
            dpc       = PC_RESET;
        end else if (exc_req | eret_req) begin
            {rst_ifid, rst_idex, rst_exmem} = 3'b111;
            pc_redirect = 1'b1;
            pc_target   = exc_req ? HANDLER_PC : epc;
            dpc         = exc_req ? HANDLER_PC : epc;
        end else if (stall) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            rst_idex = 1'b1;
        end
    end

`ifdef PIPE_FLUSH_CTRL_WDOG_EN
    logic [7:0] wcnt;
    logic       stall_act;

    assign stall_act = stall & ~exc_req & ~eret_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt          <= 8'd0;
            stall_timeout <= 1'b0;
        end else begin
            wcnt <= stall_act ? ((wcnt == 8'hff) ? wcnt : wcnt + 8'd1) : 8'd0;
            if (wcnt >= 8'(MAX_STALL))
                stall_timeout <= 1'b1;
        end
    end
`else
    assign stall_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl: directed self-checking bench for pipe_flush_ctrl.
module tb_pipe_flush_ctrl;
    logic        clk = 1'b0;
    logic        reset, hz_stall, md_use, md_start, exc_req, eret_req;
    logic [3:0]  md_cycles;
    logic [31:0] epc, d_pc, dpc, pc_target;
    logic        en_pc, en_ifid, en_idex, en_exmem;
    logic        rst_ifid, rst_idex, rst_exmem;
    logic        pc_redirect, md_busy, stall_timeout;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
`ifdef PIPE_FLUSH_CTRL_WDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    pipe_flush_ctrl #(
`ifdef PIPE_FLUSH_CTRL_WDOG_EN
        .MAX_STALL(4),
`endif
        .HANDLER_PC(32'h0000_4180),
        .PC_RESET(32'h0000_3000)
    ) dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .md_use(md_use),
        .md_start(md_start), .md_cycles(md_cycles), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .d_pc(d_pc),
        .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
        .rst_ifid(rst_ifid), .rst_idex(rst_idex), .rst_exmem(rst_exmem),
        .dpc(dpc), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .md_busy(md_busy), .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ens();
        return {28'd0, en_pc, en_ifid, en_idex, en_exmem};
    endfunction

    function automatic logic [31:0] rsts();
        return {29'd0, rst_ifid, rst_idex, rst_exmem};
    endfunction

    initial begin
        reset = 1'b0; hz_stall = 1'b0; md_use = 1'b0; md_start = 1'b1;
        md_cycles = 4'd5; exc_req = 1'b0; eret_req = 1'b0;
        epc = 32'h0; d_pc = 32'hfac1_3215;
        #3;
        chk("rst_en", ens(), 32'h0);
        chk("rst_clr", rsts(), 32'h7);
        chk("rst_dpc", dpc, 32'h3000);
        chk("rst_tgt", pc_target, 32'h3000);
        chk("rst_redir", {31'd0, pc_redirect}, 32'h0);
        chk("rst_busy", {31'd0, md_busy}, 32'h0);
        chk("rst_wdog", {31'd0, stall_timeout}, 32'h0);

        cyc(); reset = 1'b1; md_start = 1'b0; #1;
        chk("norm_en", ens(), 32'hf);
        chk("norm_clr", rsts(), 32'h0);
        chk("norm_dpc", dpc, 32'hfac1_3215);
        chk("norm_tgt", pc_target, 32'hfac1_3215);

        cyc(); hz_stall = 1'b1; d_pc = 32'h3010; #1;
        chk("hz_en", ens(), 32'h3);
        chk("hz_clr", rsts(), 32'h2);
        chk("hz_dpc", dpc, 32'h3010);
        chk("hz_redir", {31'd0, pc_redirect}, 32'h0);
        cyc(); hz_stall = 1'b0; #1;
        chk("hz_after_en", ens(), 32'hf);

        cyc(); md_start = 1'b1; md_cycles = 4'd0; md_use = 1'b1; #1;
        chk("md0_busy", {31'd0, md_busy}, 32'h0);
        chk("md0_en", ens(), 32'hf);

        cyc(); md_cycles = 4'd5; #1;
        for (int k = 0; k <= 5; k++) begin
            chk($sformatf("md5_busy_t%0d", k), {31'd0, md_busy}, 32'h1);
            chk($sformatf("md5_en_t%0d", k), ens(), 32'h3);
            cyc(); md_start = 1'b0;
            if (k == 0) #1;
        end
        #1;
        chk("md5_done_busy", {31'd0, md_busy}, 32'h0);
        chk("md5_done_en", ens(), 32'hf);
        md_use = 1'b0;

        cyc(); exc_req = 1'b1; hz_stall = 1'b1; md_start = 1'b1; md_cycles = 4'd10; d_pc = 32'h3040; #1;
        chk("exc_clr", rsts(), 32'h7);
        chk("exc_en", ens(), 32'hf);
        chk("exc_tgt", pc_target, 32'h4180);
        chk("exc_dpc", dpc, 32'h4180);
        chk("exc_redir", {31'd0, pc_redirect}, 32'h1);
        chk("exc_busy", {31'd0, md_busy}, 32'h0);
        cyc(); exc_req = 1'b0; hz_stall = 1'b0; md_start = 1'b0; #1;
        chk("exc_state_run", {31'd0, md_busy}, 32'h0);

        cyc(); md_start = 1'b1; md_cycles = 4'd10; #1;
        chk("w10_t0_busy", {31'd0, md_busy}, 32'h1);
        cyc(); md_start = 1'b0; #1;
        cyc();
        cyc(); eret_req = 1'b1; epc = 32'h3024; #1;
        chk("eret_tgt", pc_target, 32'h3024);
        chk("eret_dpc", dpc, 32'h3024);
        chk("eret_clr", rsts(), 32'h7);
        chk("eret_redir", {31'd0, pc_redirect}, 32'h1);
        chk("eret_busy", {31'd0, md_busy}, 32'h1);
        cyc(); eret_req = 1'b0; md_use = 1'b1; #1;
        chk("w10_t4_busy", {31'd0, md_busy}, 32'h1);
        chk("w10_t4_en", ens(), 32'h3);
        cyc(); cyc();
        chk("w10_t6_busy", {31'd0, md_busy}, 32'h1);
        reset = 1'b0; #1;
        chk("midrst_busy", {31'd0, md_busy}, 32'h0);
        chk("midrst_en", ens(), 32'h0);
        chk("midrst_clr", rsts(), 32'h7);
        md_use = 1'b0;
        cyc(); reset = 1'b1; #1;
        chk("post_rst_busy", {31'd0, md_busy}, 32'h0);
        chk("post_rst_en", ens(), 32'hf);

        cyc(); hz_stall = 1'b1; #1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) chk("wd_s3", {31'd0, stall_timeout}, 32'h0);
            if (k == 5) chk("wd_s5", {31'd0, stall_timeout}, {31'd0, WD});
            if (k < 5) cyc();
        end
        cyc(); hz_stall = 1'b0; #1;
        chk("wd_sticky", {31'd0, stall_timeout}, {31'd0, WD});
        chk("wd_norm_en", ens(), 32'hf);
        cyc(); cyc();
        chk("wd_sticky2", {31'd0, stall_timeout}, {31'd0, WD});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
